// File: rtl/param_data_pkg.sv
// Shared types and helpers for the parameterised data source.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents:
//   src_state_e  burst FSM states
//   LEN_W_DEF    default width of the burst-length field
//   trunc_w()    clips a 64-bit parameter value to the low w bits
package param_data_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    FINISH = 2'd2
  } src_state_e;

  localparam int LEN_W_DEF = 16;

  // Widths of 64 or more keep the whole value; the shift would overflow otherwise.
  function automatic logic [63:0] trunc_w(input logic [63:0] v, input int w);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return v & mask;
  endfunction

endpackage

// File: rtl/seq_step_counter.sv
// Arithmetic sequence register: loads A, advances by B modulo 2^WIDTH.
// Latency: new value visible the cycle after load/advance.
// Backpressure: none; the owner gates advance with its handshake.
//
// Ports:
//   clk, rst_n  clock and async active-low reset (value clears to 0)
//   load        set value to A (wins over advance)
//   advance     value <= value + B
//   value       current word
module seq_step_counter
  import param_data_pkg::*;
#(
  parameter int              WIDTH = 32,
  parameter longint unsigned A     = 1,
  parameter longint unsigned B     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             advance,
  output logic [WIDTH-1:0] value
);

  localparam logic [63:0]      A_FULL = trunc_w(A, WIDTH);
  localparam logic [63:0]      B_FULL = trunc_w(B, WIDTH);
  localparam logic [WIDTH-1:0] A_W    = A_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] B_W    = B_FULL[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= A_W;
    end else if (advance) begin
      value <= value + B_W;  // natural WIDTH-bit wrap
    end
  end

endmodule

// File: rtl/param_data_source.sv
// Burst producer: on start, emits len words A, A+B, ... over valid/ready.
// Latency: first word the cycle after start; done N+1 cycles after start at full rate.
// Backpressure: valid/data held stable while ready is low; one word per cycle otherwise.
//
// Ports:
//   clk, rst_n   clock and async active-low reset
//   start, len   burst request and word count, sampled only in IDLE
//   data, valid  offered word toward the consumer
//   ready        consumer accept
//   busy         burst in progress (SEND or FINISH)
//   done         one-cycle pulse at burst end
//   sent         words accepted in the current/last burst
module param_data_source
  import param_data_pkg::*;
#(
  parameter longint unsigned A     = 1,
  parameter int              WIDTH = 32,
  parameter longint unsigned B     = 2,
  parameter int              LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] sent
);

  src_state_e       state;
  logic [LEN_W-1:0] remaining;
  logic             valid_q;
  logic [LEN_W-1:0] sent_q;
  logic             accept;
  logic             xfer;
  logic             last_xfer;
  logic             load;
  logic             advance;

  assign accept    = (state == IDLE) && start;
  assign xfer      = (state == SEND) && valid_q && ready;
  assign last_xfer = xfer && (remaining == LEN_W'(1));

  // The last word is not advanced past, so data keeps it after the burst.
  assign load    = accept && (len != '0);
  assign advance = xfer && !last_xfer;

  seq_step_counter #(
    .WIDTH (WIDTH),
    .A     (A),
    .B     (B)
  ) u_step (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .advance (advance),
    .value   (data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      valid_q   <= 1'b0;
      sent_q    <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sent_q    <= '0;
            remaining <= len;
            if (len != '0) begin
              state   <= SEND;
              valid_q <= 1'b1;
            end else begin
              state   <= FINISH;  // empty burst still reports done
            end
          end
        end
        SEND: begin
          if (xfer) begin
            sent_q    <= sent_q + LEN_W'(1);
            remaining <= remaining - LEN_W'(1);
            if (last_xfer) begin
              state   <= FINISH;
              valid_q <= 1'b0;
            end
          end
        end
        FINISH: begin
          state <= IDLE;  // start seen here is dropped, not queued
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign valid = valid_q;
  assign sent  = sent_q;
  assign busy  = (state != IDLE);
  assign done  = (state == FINISH);

endmodule
